// File: rtl/min_key_scheduler.sv
// min_key_scheduler: snapshots pending requests and keys, then walks one
// requester per cycle through a single shared comparator to find the smallest
// key (lowest index wins ties) and presents it over a valid/ready grant.

// Shared key comparator: unsigned strict less-than.
module min_key_cmp #(
  parameter int input_size = 8
) (
  input  logic [input_size-1:0] input1,
  input  logic [input_size-1:0] input2,
  output logic                  less
);
  assign less = (input1 < input2);
endmodule

module min_key_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int KEY_WIDTH = 8,
  parameter int IDX_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*KEY_WIDTH-1:0] keys,
  output logic                         grant_valid,
  input  logic                         grant_ready,
  output logic [IDX_WIDTH-1:0]         grant_idx,
  output logic [KEY_WIDTH-1:0]         grant_key,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_REQ - 1);

  state_t                              state_q, state_d;
  logic [IDX_WIDTH-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0]                  snap_req_q, snap_req_d;
  logic [NUM_REQ-1:0][KEY_WIDTH-1:0]   snap_keys_q, snap_keys_d;
  logic [IDX_WIDTH-1:0]                best_idx_q, best_idx_d;
  logic [KEY_WIDTH-1:0]                best_key_q, best_key_d;
  logic                                best_valid_q, best_valid_d;
  logic                                grant_valid_q, grant_valid_d;
  logic [IDX_WIDTH-1:0]                grant_idx_q, grant_idx_d;
  logic [KEY_WIDTH-1:0]                grant_key_q, grant_key_d;
  logic                                busy_q, busy_d;

  logic                                cmp_less;
  logic                                take;
  logic [IDX_WIDTH-1:0]                cand_idx;
  logic [KEY_WIDTH-1:0]                cand_key;

  // The one comparator: current scanned key against the running best.
  min_key_cmp #(.input_size(KEY_WIDTH)) u_cmp (
    .input1 (snap_keys_q[ptr_q]),
    .input2 (best_key_q),
    .less   (cmp_less)
  );

  // Next-state: capture in IDLE, one compare per SCAN cycle, hold in GRANT.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    snap_req_d    = snap_req_q;
    snap_keys_d   = snap_keys_q;
    best_idx_d    = best_idx_q;
    best_key_d    = best_key_q;
    best_valid_d  = best_valid_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    grant_key_d   = grant_key_q;
    // Equal keys keep the incumbent, so the lowest index wins ties.
    take          = snap_req_q[ptr_q] && (!best_valid_q || cmp_less);
    cand_idx      = take ? ptr_q : best_idx_q;
    cand_key      = take ? snap_keys_q[ptr_q] : best_key_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          snap_req_d   = req;
          snap_keys_d  = keys;
          ptr_d        = '0;
          best_valid_d = 1'b0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        best_idx_d   = cand_idx;
        best_key_d   = cand_key;
        best_valid_d = best_valid_q | take;
        if (ptr_q == LAST) begin
          grant_idx_d   = cand_idx;
          grant_key_d   = cand_key;
          grant_valid_d = 1'b1;
          state_d       = GRANT;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any pending grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      snap_req_q    <= '0;
      snap_keys_q   <= '0;
      best_idx_q    <= '0;
      best_key_q    <= '0;
      best_valid_q  <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_key_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      snap_req_q    <= snap_req_d;
      snap_keys_q   <= snap_keys_d;
      best_idx_q    <= best_idx_d;
      best_key_q    <= best_key_d;
      best_valid_q  <= best_valid_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_key_q   <= grant_key_d;
      busy_q        <= busy_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign grant_key   = grant_key_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_min_key_scheduler.sv
// tb_min_key_scheduler: directed cases plus randomized grants checked against
// a min-search reference model.
module tb_min_key_scheduler;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*KW-1:0] keys;
  logic            grant_valid;
  logic            grant_ready;
  logic [IW-1:0]   grant_idx;
  logic [KW-1:0]   grant_key;
  logic            busy;

  int n_chk  = 0;
  int n_fail = 0;

  min_key_scheduler #(.NUM_REQ(N), .KEY_WIDTH(KW), .IDX_WIDTH(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .keys        (keys),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_idx   (grant_idx),
    .grant_key   (grant_key),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: smallest requested key value, then the lowest index holding it.
  task automatic ref_min(input logic [N-1:0] r, input logic [N*KW-1:0] k,
                         output int idx, output int key);
    int mn;
    mn = 1 << KW;
    for (int i = 0; i < N; i++)
      if (r[i] && int'(k[i*KW +: KW]) < mn) mn = int'(k[i*KW +: KW]);
    idx = -1;
    for (int i = N - 1; i >= 0; i--)
      if (r[i] && int'(k[i*KW +: KW]) == mn) idx = i;
    key = mn;
  endtask

  // One full transaction from an IDLE DUT. With chg set, inputs switch to
  // alt_r/alt_k right after capture and are re-randomized while the grant waits.
  task automatic run_grant(input logic [N-1:0] r, input logic [N*KW-1:0] k, input int dly,
                           input bit chg, input logic [N-1:0] alt_r, input logic [N*KW-1:0] alt_k);
    int ei, ek;
    ref_min(r, k, ei, ek);
    req = r; keys = k; grant_ready = (dly == 0);
    tick();
    chk("cap_busy", 32'(busy), 32'd1);
    chk("cap_vld", 32'(grant_valid), 32'd0);
    if (chg) begin req = alt_r; keys = alt_k; end
    for (int i = 1; i < N; i++) begin
      tick();
      chk("scan_vld", 32'(grant_valid), 32'd0);
      chk("scan_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("gnt_vld", 32'(grant_valid), 32'd1);
    chk("gnt_idx", 32'(grant_idx), 32'(ei));
    chk("gnt_key", 32'(grant_key), 32'(ek));
    for (int d = 0; d < dly; d++) begin
      if (chg) begin req = N'($urandom); keys = $urandom; end
      tick();
      chk("hold_vld", 32'(grant_valid), 32'd1);
      chk("hold_idx", 32'(grant_idx), 32'(ei));
      chk("hold_key", 32'(grant_key), 32'(ek));
      chk("hold_busy", 32'(busy), 32'd1);
    end
    grant_ready = 1'b1;
    tick();
    chk("done_vld", 32'(grant_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_idx", 32'(grant_idx), 32'(ei));
    chk("done_key", 32'(grant_key), 32'(ek));
    req = '0; grant_ready = 1'b0;
  endtask

  function automatic logic [N*KW-1:0] rand_keys();
    logic [N*KW-1:0] k;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       k[i*KW +: KW] = KW'($urandom_range(0, 3));
        1:       k[i*KW +: KW] = '1;
        default: k[i*KW +: KW] = KW'($urandom);
      endcase
    end
    return k;
  endfunction

  initial begin
    reset = 1'b1; req = 4'b1111; keys = 32'h40108020; grant_ready = 1'b1;
    // Outputs stay cleared while reset is held with requests pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_vld", 32'(grant_valid), 32'd0);
      chk("rst_idx", 32'(grant_idx), 32'd0);
      chk("rst_key", 32'(grant_key), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    // First edge after reset release captures; idx 2 holds 0x10.
    run_grant(4'b1111, 32'h40108020, 0, 1'b0, '0, '0);

    // No requests: remain idle.
    req = '0;
    tick(); tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_vld", 32'(grant_valid), 32'd0);

    // Tie on 0x33 between idx1 and idx2; single request with all-ones key.
    run_grant(4'b0110, 32'h00333300, 0, 1'b0, '0, '0);
    run_grant(4'b1000, 32'hFF000000, 1, 1'b0, '0, '0);
    chk("ff_idx_kept", 32'(grant_idx), 32'd3);
    chk("ff_key_kept", 32'(grant_key), 32'hFF);

    // Backpressure for 3 cycles with inputs churning.
    run_grant(4'b1111, 32'h40108020, 3, 1'b1, 4'b0001, 32'hFFFFFF01);
    // idx0 made smallest during SCAN: snapshot still grants idx2.
    run_grant(4'b1111, 32'h40108020, 0, 1'b1, 4'b1111, 32'h40108000);

    // Reset at ptr=2 drops the scan; held request then re-captures.
    req = 4'b1011; keys = 32'h05FF0709;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(grant_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_idx", 32'(grant_idx), 32'd0);
    chk("mid_rst_key", 32'(grant_key), 32'd0);
    reset = 1'b0;
    run_grant(4'b1011, 32'h05FF0709, 0, 1'b0, '0, '0);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(1, (1 << N) - 1));
      run_grant(r, rand_keys(), $urandom_range(0, 3), 1'($urandom),
                N'($urandom), rand_keys());
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("gap_busy", 32'(busy), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
